// File: rtl/axi4_burst_mem.sv
// axi4_burst_mem: AXI4 slave memory with independent read and write engines.
// Supports FIXED, INCR and WRAP bursts up to 256 beats, byte strobes and
// per-beat SLVERR reporting.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   aw*/w*/b*            write address, write data and write response channels
//   ar*/r*               read address and read data channels
//   w_state_dbg          current write FSM state (0 idle, 1 data, 2 resp)
//   r_state_dbg          current read FSM state (0 idle, 1 data)
//
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where valid and ready are both 1; valid never depends on ready, and the
// payload is held stable while valid=1 and ready=0.
module axi4_burst_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [1:0]              w_state_dbg,
    output logic [1:0]              r_state_dbg
);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1} r_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] wrap_mask;
        step      = ADDR_WIDTH'(1) << size;
        // WRAP block is (len+1)*2^size bytes and aligned to its own size
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default: next_addr = addr + step;
        endcase
    endfunction

    // Bursts that error on every beat without touching memory
    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        burst_bad = (int'(size) > LOG2_BYTES) || (burst == 2'b11) ||
                    ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                           (len == 8'd7) || (len == 8'd15)));
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Keeps both ready outputs low until the first edge after reset release
    logic ready_en;

    // ---------------- write engine ----------------
    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr, w_word;
    logic [7:0]            w_len, w_beat;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_burst_err, w_err;
    logic                  w_fire, w_last_beat, w_in_range, w_beat_ok, w_mem_en;

    assign w_word      = w_addr >> LOG2_BYTES;
    assign w_in_range  = 32'(w_word) < 32'(MEM_DEPTH);
    assign w_fire      = wvalid && wready;
    assign w_last_beat = (w_beat == w_len);
    // wlast must be present exactly on the final beat
    assign w_beat_ok   = w_in_range && (wlast == w_last_beat);
    assign w_mem_en    = w_fire && !w_burst_err && w_in_range;
    assign w_state_dbg = w_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = ready_en;
                if (awvalid && ready_en) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en    <= 1'b0;
            w_addr      <= '0;
            w_len       <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_beat      <= '0;
            w_burst_err <= 1'b0;
            w_err       <= 1'b0;
            bresp       <= 2'b00;
        end else begin
            ready_en <= 1'b1;
            if (awvalid && awready) begin
                w_addr      <= awaddr;
                w_len       <= awlen;
                w_size      <= awsize;
                w_burst     <= awburst;
                w_beat      <= '0;
                w_burst_err <= burst_bad(awlen, awsize, awburst);
                w_err       <= 1'b0;
            end
            if (w_fire) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                w_beat <= w_beat + 8'd1;
                w_err  <= w_err | !w_beat_ok;
                // Response is sticky across the whole burst
                if (w_last_beat)
                    bresp <= (w_err || !w_beat_ok || w_burst_err) ? 2'b10 : 2'b00;
            end
            if (bvalid && bready) bresp <= 2'b00;
        end
    end

    // Memory is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (w_mem_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_word[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_load_addr, r_load_word;
    logic [7:0]            r_len, r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_burst_err;
    logic                  ar_fire, r_fire, r_load, r_load_bad, r_load_ok;

    assign ar_fire     = arvalid && arready;
    assign r_fire      = rvalid && rready;
    // The beat register is refilled on the AR handshake and on every
    // non-final R handshake, so beat data appears one edge after acceptance.
    assign r_load      = ar_fire || (r_fire && !rlast);
    assign r_load_addr = ar_fire ? araddr : next_addr(r_addr, r_len, r_size, r_burst);
    assign r_load_bad  = ar_fire ? burst_bad(arlen, arsize, arburst) : r_burst_err;
    assign r_load_word = r_load_addr >> LOG2_BYTES;
    assign r_load_ok   = !r_load_bad && (32'(r_load_word) < 32'(MEM_DEPTH));
    assign r_state_dbg = {1'b0, r_state == R_DATA};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = ready_en;
                if (arvalid && ready_en) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_beat == r_len);
                if (rready && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_burst_err <= 1'b0;
            rdata       <= '0;
            rresp       <= 2'b00;
        end else begin
            if (ar_fire) begin
                r_len       <= arlen;
                r_size      <= arsize;
                r_burst     <= arburst;
                r_beat      <= '0;
                r_burst_err <= burst_bad(arlen, arsize, arburst);
            end
            if (r_load) begin
                r_addr <= r_load_addr;
                // Same-cycle write lands after this sample, so reads see old data
                rdata  <= r_load_ok ? mem[r_load_word[IDX_W-1:0]] : '0;
                rresp  <= r_load_ok ? 2'b00 : 2'b10;
            end
            if (r_fire && !rlast) r_beat <= r_beat + 8'd1;
            if (r_fire && rlast) begin
                rdata <= '0;
                rresp <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi4_burst_mem.sv
module tb_axi4_burst_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, rlast, rvalid, rready;
    logic [1:0]  w_state_dbg, r_state_dbg;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [1:0]  resp;

    axi4_burst_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [15:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [31:0] base, input logic [3:0] strb,
                               input bit bad_wlast, input int bhold,
                               output logic [1:0] r);
        int n;
        logic [1:0] held;
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        check("aw_ready_seen", {31'b0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("aw_busy", {31'b0, awready}, 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = base + 32'(i);
            wstrb = strb;
            wlast = bad_wlast ? 1'b0 : (i == int'(len));
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(posedge clk); #1; n++; end
            check("w_ready_seen", {31'b0, wready}, 32'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("b_valid_seen", {31'b0, bvalid}, 32'd1);
        held = bresp;
        for (int k = 0; k < bhold; k++) begin
            @(posedge clk); #1;
            check("b_hold_valid", {31'b0, bvalid}, 32'd1);
            check("b_hold_resp", {30'b0, bresp}, {30'b0, held});
        end
        r = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("b_done", {31'b0, bvalid}, 32'd0);
        check("aw_ready_back", {31'b0, awready}, 32'd1);
    endtask

    task automatic read_burst(input logic [15:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input bit toggle);
        int n, i;
        logic stall_prev;
        logic [31:0] hold_d;
        logic [1:0] hold_r;
        logic hold_l;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        check("ar_ready_seen", {31'b0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("ar_busy", {31'b0, arready}, 32'd0);
        i = 0; n = 0; stall_prev = 1'b0;
        hold_d = '0; hold_r = '0; hold_l = 1'b0;
        while (i <= int'(len) && n < 2000) begin
            rready = toggle ? (n % 2 == 1) : 1'b1;
            if (stall_prev) begin
                check("r_hold_data", rdata, hold_d);
                check("r_hold_resp", {30'b0, rresp}, {30'b0, hold_r});
                check("r_hold_last", {31'b0, rlast}, {31'b0, hold_l});
            end
            stall_prev = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast;
                    i++;
                end else begin
                    hold_d = rdata; hold_r = rresp; hold_l = rlast;
                    stall_prev = 1'b1;
                end
            end
            @(posedge clk); #1;
            n++;
        end
        rready = 1'b0;
        check("r_beats_done", 32'(i), 32'(len) + 32'd1);
        check("r_idle", {31'b0, rvalid}, 32'd0);
        check("ar_ready_back", {31'b0, arready}, 32'd1);
    endtask

    task automatic check_beat(input string tag, input int i, input logic [31:0] d,
                              input logic [1:0] r, input logic l);
        check({tag, "_data"}, rd_data[i], d);
        check({tag, "_resp"}, {30'b0, rd_resp[i]}, {30'b0, r});
        check({tag, "_last"}, {31'b0, rd_last[i]}, {31'b0, l});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, {31'b0, awready}, 32'd0);
        check({tag, "_wready"}, {31'b0, wready}, 32'd0);
        check({tag, "_bvalid"}, {31'b0, bvalid}, 32'd0);
        check({tag, "_arready"}, {31'b0, arready}, 32'd0);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd0);
        check({tag, "_rlast"}, {31'b0, rlast}, 32'd0);
        check({tag, "_bresp"}, {30'b0, bresp}, 32'd0);
        check({tag, "_rresp"}, {30'b0, rresp}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_wstate"}, {30'b0, w_state_dbg}, 32'd0);
        check({tag, "_rstate"}, {30'b0, r_state_dbg}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        check("awready_before_edge", {31'b0, awready}, 32'd0);
        @(posedge clk); #1;
        check("awready_after_release", {31'b0, awready}, 32'd1);
        check("arready_after_release", {31'b0, arready}, 32'd1);

        // INCR write and read-back
        write_burst(16'h0010, 8'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 1'b0, 0, resp);
        check("incr_bresp", {30'b0, resp}, 32'd0);
        read_burst(16'h0010, 8'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) check_beat("incr_rd", i, 32'hA0 + 32'(i), 2'b00, i == 3);

        // WRAP read: 0x18, 0x1C, 0x10, 0x14
        read_burst(16'h0018, 8'd3, 3'd2, 2'b10, 1'b0);
        check_beat("wrap_b0", 0, 32'hA2, 2'b00, 1'b0);
        check_beat("wrap_b1", 1, 32'hA3, 2'b00, 1'b0);
        check_beat("wrap_b2", 2, 32'hA0, 2'b00, 1'b0);
        check_beat("wrap_b3", 3, 32'hA1, 2'b00, 1'b1);

        // Byte strobes
        write_burst(16'h0040, 8'd0, 3'd2, 2'b01, 32'hFFFFFFFF, 4'hF, 1'b0, 0, resp);
        write_burst(16'h0040, 8'd0, 3'd2, 2'b01, 32'h12345678, 4'b0101, 1'b0, 0, resp);
        check("strb_bresp", {30'b0, resp}, 32'd0);
        read_burst(16'h0040, 8'd0, 3'd2, 2'b01, 1'b0);
        check_beat("strb_rd", 0, 32'hFF34FF78, 2'b00, 1'b1);

        // Out of range: word 1023 ok, word 1024 errs
        write_burst(16'h0FFC, 8'd1, 3'd2, 2'b01, 32'hE0, 4'hF, 1'b0, 0, resp);
        check("oor_bresp", {30'b0, resp}, 32'd2);
        read_burst(16'h0FFC, 8'd1, 3'd2, 2'b01, 1'b0);
        check_beat("oor_rd0", 0, 32'hE0, 2'b00, 1'b0);
        check_beat("oor_rd1", 1, 32'h0, 2'b10, 1'b1);

        // Whole-burst errors
        write_burst(16'h0050, 8'd0, 3'd2, 2'b01, 32'h11111111, 4'hF, 1'b0, 0, resp);
        check("pre50_bresp", {30'b0, resp}, 32'd0);
        write_burst(16'h0050, 8'd0, 3'd2, 2'b11, 32'h22222222, 4'hF, 1'b0, 0, resp);
        check("rsvd_bresp", {30'b0, resp}, 32'd2);
        write_burst(16'h0050, 8'd2, 3'd2, 2'b10, 32'h33333333, 4'hF, 1'b0, 0, resp);
        check("wrap3_bresp", {30'b0, resp}, 32'd2);
        read_burst(16'h0050, 8'd0, 3'd2, 2'b01, 1'b0);
        check_beat("rsvd_nowrite", 0, 32'h11111111, 2'b00, 1'b1);
        read_burst(16'h0010, 8'd2, 3'd2, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) check_beat("wrap3_rd", i, 32'h0, 2'b10, i == 2);
        read_burst(16'h0010, 8'd0, 3'd3, 2'b01, 1'b0);
        check_beat("size_rd", 0, 32'h0, 2'b10, 1'b1);
        write_burst(16'h0058, 8'd1, 3'd2, 2'b01, 32'h44, 4'hF, 1'b1, 0, resp);
        check("nowlast_bresp", {30'b0, resp}, 32'd2);

        // FIXED burst: last beat wins
        write_burst(16'h0060, 8'd2, 3'd2, 2'b00, 32'h70, 4'hF, 1'b0, 0, resp);
        check("fixed_bresp", {30'b0, resp}, 32'd0);
        read_burst(16'h0060, 8'd2, 3'd2, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) check_beat("fixed_rd", i, 32'h72, 2'b00, i == 2);

        // Concurrent read with backpressure and write with held bready
        write_burst(16'h0000, 8'd3, 3'd2, 2'b01, 32'hB0, 4'hF, 1'b0, 0, resp);
        fork
            read_burst(16'h0000, 8'd3, 3'd2, 2'b01, 1'b1);
            write_burst(16'h0100, 8'd3, 3'd2, 2'b01, 32'hD0, 4'hF, 1'b0, 5, resp);
        join
        check("conc_bresp", {30'b0, resp}, 32'd0);
        for (int i = 0; i < 4; i++) check_beat("conc_rd", i, 32'hB0 + 32'(i), 2'b00, i == 3);
        read_burst(16'h0100, 8'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) check_beat("conc_wr", i, 32'hD0 + 32'(i), 2'b00, i == 3);

        // Reset during beat 2 of an 8-beat write
        write_burst(16'h0208, 8'd0, 3'd2, 2'b01, 32'h55, 4'hF, 1'b0, 0, resp);
        awaddr = 16'h0200; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'hC0 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            @(posedge clk); #1;
        end
        wdata = 32'hC2;
        check("rst_beat2_wready", {31'b0, wready}, 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_awready_low", {31'b0, awready}, 32'd0);
        @(posedge clk); #1;
        check("midrst_awready_high", {31'b0, awready}, 32'd1);
        read_burst(16'h0200, 8'd2, 3'd2, 2'b01, 1'b0);
        check_beat("midrst_b0", 0, 32'hC0, 2'b00, 1'b0);
        check_beat("midrst_b1", 1, 32'hC1, 2'b00, 1'b0);
        check_beat("midrst_b2", 2, 32'h55, 2'b00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
